// File: rtl/int_handler.sv
// Interrupt front-end: synchronises and edge-detects request lines, masks them,
// picks the lowest eligible index, redirects the PC and saves the return address.
module int_handler #(
    parameter int unsigned N_IRQ    = 4,
    parameter logic [31:0] VEC_BASE = 32'h0000_0004
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_IRQ-1:0]         irq,
    input  logic                     mask_we,
    input  logic [N_IRQ-1:0]         mask_d,
    input  logic [31:0]              pc_next,
    input  logic                     cpu_stall,
    input  logic                     eret,
    output logic                     int_req,
    output logic [31:0]              int_vector,
    output logic [31:0]              epc,
    output logic                     int_code,
    output logic [$clog2(N_IRQ)-1:0] int_id,
    output logic [N_IRQ-1:0]         int_ack,
    output logic [N_IRQ-1:0]         mask
);

    localparam int unsigned ID_W = $clog2(N_IRQ);

    typedef enum logic [1:0] {
        IDLE,
        TAKE,
        SERVICE
    } state_t;

    state_t            state_q, state_d;
    logic [N_IRQ-1:0]  s1_q, s1_d;
    logic [N_IRQ-1:0]  s2_q, s2_d;
    logic [N_IRQ-1:0]  s2_dly_q, s2_dly_d;
    logic [N_IRQ-1:0]  pending_q, pending_d;
    logic [N_IRQ-1:0]  mask_reg_q, mask_reg_d;
    logic [N_IRQ-1:0]  int_ack_q, int_ack_d;
    logic [ID_W-1:0]   int_id_q, int_id_d;
    logic [31:0]       epc_q, epc_d;
    logic              int_req_q, int_req_d;
    logic              int_code_q, int_code_d;

    logic [N_IRQ-1:0]  edge_set;
    logic [N_IRQ-1:0]  eligible;
    logic [N_IRQ-1:0]  take_clr;
    logic [N_IRQ-1:0]  take_onehot;
    logic [ID_W-1:0]   winner;
    logic              found;

    always_comb begin
        s1_d       = irq;
        s2_d       = s1_q;
        s2_dly_d   = s2_q;
        edge_set   = s2_q & ~s2_dly_q;
        // Eligibility uses the mask as it stands before any write at this edge.
        eligible   = pending_q & mask_reg_q;
        mask_reg_d = mask_we ? mask_d : mask_reg_q;

        winner = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (eligible[i] && !found) begin
                found  = 1'b1;
                winner = ID_W'(i);
            end
        end

        take_onehot = N_IRQ'(1) << int_id_q;
        state_d     = state_q;
        int_id_d    = int_id_q;
        epc_d       = epc_q;
        take_clr    = '0;
        int_ack_d   = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = TAKE;
                    int_id_d = winner;
                end
            end
            TAKE: begin
                if (!cpu_stall) begin
                    epc_d     = pc_next;
                    take_clr  = take_onehot;
                    int_ack_d = take_onehot;
                    state_d   = SERVICE;
                end
            end
            SERVICE: begin
                if (eret) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new edge arriving on the take edge survives the clear.
        pending_d  = (pending_q & ~take_clr) | edge_set;
        int_req_d  = (state_d == TAKE);
        int_code_d = (state_d == SERVICE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            s1_q       <= '0;
            s2_q       <= '0;
            s2_dly_q   <= '0;
            pending_q  <= '0;
            mask_reg_q <= '0;
            int_ack_q  <= '0;
            int_id_q   <= '0;
            epc_q      <= '0;
            int_req_q  <= 1'b0;
            int_code_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s2_dly_q   <= s2_dly_d;
            pending_q  <= pending_d;
            mask_reg_q <= mask_reg_d;
            int_ack_q  <= int_ack_d;
            int_id_q   <= int_id_d;
            epc_q      <= epc_d;
            int_req_q  <= int_req_d;
            int_code_q <= int_code_d;
        end
    end

    assign int_req    = int_req_q;
    assign int_code   = int_code_q;
    assign int_ack    = int_ack_q;
    assign int_id     = int_id_q;
    assign epc        = epc_q;
    assign mask       = mask_reg_q;
    assign int_vector = VEC_BASE + (32'(int_id_q) << 3);

endmodule

// File: tb/tb_int_handler.sv
// Directed self-checking bench for int_handler; outputs sampled 1 time unit after each rising edge.
module tb_int_handler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq;
    logic        mask_we;
    logic [3:0]  mask_d;
    logic [31:0] pc_next;
    logic        cpu_stall;
    logic        eret;
    logic        int_req;
    logic [31:0] int_vector;
    logic [31:0] epc;
    logic        int_code;
    logic [1:0]  int_id;
    logic [3:0]  int_ack;
    logic [3:0]  mask;

    int n_checks = 0;
    int n_fail   = 0;

    int_handler #(
        .N_IRQ   (4),
        .VEC_BASE(32'h0000_0004)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irq       (irq),
        .mask_we   (mask_we),
        .mask_d    (mask_d),
        .pc_next   (pc_next),
        .cpu_stall (cpu_stall),
        .eret      (eret),
        .int_req   (int_req),
        .int_vector(int_vector),
        .epc       (epc),
        .int_code  (int_code),
        .int_id    (int_id),
        .int_ack   (int_ack),
        .mask      (mask)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_mask(input logic [3:0] m);
        mask_we = 1'b1;
        mask_d  = m;
        step(1);
        mask_we = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; irq = '0; mask_we = 1'b0; mask_d = '0;
        pc_next = 32'h40; cpu_stall = 1'b0; eret = 1'b0;
        step(3);
        rst = 1'b0;
        step(1);
        n_checks++;
        if ({int_req, int_code, int_ack, int_id, mask} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got req=%b code=%b ack=%b id=%0d mask=%b, want all 0",
                     int_req, int_code, int_ack, int_id, mask);
        end
        n_checks++;
        if (epc !== 32'h0) begin
            n_fail++; $display("FAIL reset_epc: got %h want 00000000", epc);
        end
    endtask

    task automatic test_single;
        write_mask(4'b0001);
        pc_next = 32'h40;
        irq = 4'b0001;
        for (int e = 0; e < 3; e++) begin
            step(1);
            n_checks++;
            if (int_req !== 1'b0) begin
                n_fail++; $display("FAIL single_early_req E%0d: got %b want 0", e, int_req);
            end
        end
        step(1);
        n_checks++;
        if ({int_req, int_id, int_vector} !== {1'b1, 2'd0, 32'h4}) begin
            n_fail++;
            $display("FAIL single_take: got req=%b id=%0d vec=%h want 1 0 00000004",
                     int_req, int_id, int_vector);
        end
        step(1);
        n_checks++;
        if ({int_req, int_code, int_ack, epc} !== {1'b0, 1'b1, 4'b0001, 32'h40}) begin
            n_fail++;
            $display("FAIL single_service: got req=%b code=%b ack=%b epc=%h want 0 1 0001 00000040",
                     int_req, int_code, int_ack, epc);
        end
        step(1);
        n_checks++;
        if ({int_ack, int_code} !== {4'b0000, 1'b1}) begin
            n_fail++; $display("FAIL single_ack_pulse: got ack=%b code=%b want 0000 1", int_ack, int_code);
        end
        irq = '0;
        eret = 1'b1;
        step(1);
        eret = 1'b0;
        n_checks++;
        if ({int_code, int_req} !== 2'b00) begin
            n_fail++; $display("FAIL single_eret: got code=%b req=%b want 0 0", int_code, int_req);
        end
        step(4);
    endtask

    task automatic test_back_to_back;
        write_mask(4'b1111);
        irq = 4'b1010;
        step(4);
        n_checks++;
        if ({int_req, int_id, int_vector} !== {1'b1, 2'd1, 32'h0C}) begin
            n_fail++;
            $display("FAIL prio_take: got req=%b id=%0d vec=%h want 1 1 0000000c", int_req, int_id, int_vector);
        end
        step(1);
        n_checks++;
        if ({int_code, int_ack} !== {1'b1, 4'b0010}) begin
            n_fail++; $display("FAIL prio_ack: got code=%b ack=%b want 1 0010", int_code, int_ack);
        end
        eret = 1'b1;
        step(1);
        eret = 1'b0;
        n_checks++;
        if ({int_code, int_req} !== 2'b00) begin
            n_fail++; $display("FAIL b2b_eret: got code=%b req=%b want 0 0", int_code, int_req);
        end
        step(1);
        n_checks++;
        if ({int_req, int_id, int_vector} !== {1'b1, 2'd3, 32'h1C}) begin
            n_fail++;
            $display("FAIL b2b_take: got req=%b id=%0d vec=%h want 1 3 0000001c", int_req, int_id, int_vector);
        end
        step(1);
        n_checks++;
        if ({int_code, int_ack} !== {1'b1, 4'b1000}) begin
            n_fail++; $display("FAIL b2b_ack: got code=%b ack=%b want 1 1000", int_code, int_ack);
        end
        irq = '0;
        eret = 1'b1;
        step(1);
        eret = 1'b0;
        step(4);
    endtask

    task automatic test_mask;
        write_mask(4'b0000);
        irq = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            step(1);
            n_checks++;
            if (int_req !== 1'b0) begin
                n_fail++; $display("FAIL masked_req cycle %0d: got %b want 0", c, int_req);
            end
        end
        write_mask(4'b0100);
        n_checks++;
        if ({int_req, mask} !== {1'b0, 4'b0100}) begin
            n_fail++; $display("FAIL mask_write_edge: got req=%b mask=%b want 0 0100", int_req, mask);
        end
        step(1);
        n_checks++;
        if ({int_req, int_id, int_vector} !== {1'b1, 2'd2, 32'h14}) begin
            n_fail++;
            $display("FAIL unmask_take: got req=%b id=%0d vec=%h want 1 2 00000014", int_req, int_id, int_vector);
        end
        step(1);
        n_checks++;
        if ({int_code, int_ack} !== {1'b1, 4'b0100}) begin
            n_fail++; $display("FAIL unmask_ack: got code=%b ack=%b want 1 0100", int_code, int_ack);
        end
        irq = '0;
        eret = 1'b1;
        step(1);
        eret = 1'b0;
        step(4);
    endtask

    task automatic test_stall;
        write_mask(4'b0001);
        pc_next = 32'h80;
        irq = 4'b0001;
        step(4);
        cpu_stall = 1'b1;
        n_checks++;
        if (int_req !== 1'b1) begin
            n_fail++; $display("FAIL stall_enter: got req=%b want 1", int_req);
        end
        for (int c = 0; c < 3; c++) begin
            if (c == 1) pc_next = 32'h84;
            step(1);
            n_checks++;
            if ({int_req, int_code, int_ack, epc} !== {1'b1, 1'b0, 4'b0000, 32'h40}) begin
                n_fail++;
                $display("FAIL stall_hold %0d: got req=%b code=%b ack=%b epc=%h want 1 0 0000 00000040",
                         c, int_req, int_code, int_ack, epc);
            end
        end
        cpu_stall = 1'b0;
        step(1);
        n_checks++;
        if ({int_req, int_code, int_ack, epc} !== {1'b0, 1'b1, 4'b0001, 32'h84}) begin
            n_fail++;
            $display("FAIL stall_release: got req=%b code=%b ack=%b epc=%h want 0 1 0001 00000084",
                     int_req, int_code, int_ack, epc);
        end
        step(1);
        n_checks++;
        if (int_ack !== 4'b0000) begin
            n_fail++; $display("FAIL stall_single_ack: got %b want 0000", int_ack);
        end
        irq = '0;
        eret = 1'b1;
        step(1);
        eret = 1'b0;
        step(4);
    endtask

    task automatic test_spurious_collapse;
        eret = 1'b1;
        step(1);
        eret = 1'b0;
        step(1);
        n_checks++;
        if ({int_req, int_code, int_ack, epc} !== {1'b0, 1'b0, 4'b0000, 32'h84}) begin
            n_fail++;
            $display("FAIL spurious_eret: got req=%b code=%b ack=%b epc=%h want 0 0 0000 00000084",
                     int_req, int_code, int_ack, epc);
        end
        pc_next = 32'h88;
        irq = 4'b0001;
        step(5);
        n_checks++;
        if ({int_code, epc} !== {1'b1, 32'h88}) begin
            n_fail++; $display("FAIL collapse_service: got code=%b epc=%h want 1 00000088", int_code, epc);
        end
        for (int t = 0; t < 4; t++) begin
            irq = (t % 2 == 0) ? 4'b0000 : 4'b0001;
            step(3);
        end
        irq = '0;
        step(3);
        n_checks++;
        if ({int_req, int_code} !== 2'b01) begin
            n_fail++; $display("FAIL collapse_hold: got req=%b code=%b want 0 1", int_req, int_code);
        end
        eret = 1'b1;
        step(1);
        eret = 1'b0;
        step(1);
        n_checks++;
        if ({int_req, int_id} !== {1'b1, 2'd0}) begin
            n_fail++; $display("FAIL collapse_retake: got req=%b id=%0d want 1 0", int_req, int_id);
        end
        step(1);
        eret = 1'b1;
        step(1);
        eret = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step(1);
            n_checks++;
            if (int_req !== 1'b0) begin
                n_fail++; $display("FAIL collapse_once cycle %0d: got req=%b want 0", c, int_req);
            end
        end
    endtask

    task automatic test_reset_mid_service;
        pc_next = 32'h40;
        irq = 4'b0011;
        step(5);
        n_checks++;
        if ({int_code, epc} !== {1'b1, 32'h40}) begin
            n_fail++; $display("FAIL rst_pre_service: got code=%b epc=%h want 1 00000040", int_code, epc);
        end
        irq = '0;
        step(3);
        rst = 1'b1;
        step(1);
        n_checks++;
        if ({int_code, int_req, mask, epc} !== {1'b0, 1'b0, 4'b0000, 32'h0}) begin
            n_fail++;
            $display("FAIL rst_mid_service: got code=%b req=%b mask=%b epc=%h want 0 0 0000 00000000",
                     int_code, int_req, mask, epc);
        end
        rst = 1'b0;
        write_mask(4'b1111);
        for (int c = 0; c < 8; c++) begin
            step(1);
            n_checks++;
            if ({int_req, int_code} !== 2'b00) begin
                n_fail++; $display("FAIL rst_pending_cleared cycle %0d: got req=%b code=%b want 0 0",
                                   c, int_req, int_code);
            end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_mask;
        test_stall;
        test_spurious_collapse;
        test_reset_mid_service;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/int_handler.md
# int_handler

Interrupt front-end for the single-cycle interrupt-capable CPU. It synchronises and latches peripheral interrupt requests, applies a software mask, and picks the highest-priority eligible request. It redirects the PC to that request's vector and saves the return address (EPC). It raises `int_code` to the controller while a handler is in service and retires the service when the controller signals `eret`. One level, no nesting.

## Interface
Parameters:
- `N_IRQ`, 4: number of request lines (2..8).
- `VEC_BASE`, 32'h0000_0004: vector of request 0.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `irq`  in  N_IRQ  asynchronous level requests; the rising edge counts as a request.
- `mask_we`  in  1  mask write strobe.
- `mask_d`  in  N_IRQ  new mask value (1 = enabled).
- `pc_next`  in  32  the PC the CPU would load at the coming edge.
- `cpu_stall`  in  1  CPU frozen this cycle (e.g. MIO not ready); the PC does not advance.
- `eret`  in  1  return-from-interrupt from the controller.
- `int_req`  out  1  PC mux select: load `int_vector` at this edge.
- `int_vector`  out  32  handler address.
- `epc`  out  32  saved return address; the PC mux uses it on `eret`.
- `int_code`  out  1  handler in service; gates `eret` in the controller.
- `int_id`  out  $clog2(N_IRQ)  index of the request taken or in service.
- `int_ack`  out  N_IRQ  one-hot, one-cycle acknowledge to the peripheral.
- `mask`  out  N_IRQ  current mask register.

## Operation
- Synchroniser: two flops per line (`s1`, `s2`) plus a delayed copy `s2_d`.
  - `pending[i]` is set when `s2[i] & ~s2_d[i]`.
  - `pending[i]` is cleared when request i is taken.
  - If set and clear hit the same edge, set wins.
  - Repeated edges while a line is pending collapse into one request.
- Mask: on `mask_we`, `mask <= mask_d` at the edge. Eligibility each cycle is `pending & mask`, using the register value before the write.
- Priority: fixed; the lowest index wins.
- `int_vector = VEC_BASE + 8*int_id`, 32-bit, wraps modulo 2^32.
- States:
  - IDLE:
    - If eligible ≠ 0: latch `int_id` = winner and go to TAKE.
    - Otherwise stay in IDLE.
  - TAKE:
    - `int_req`=1.
    - If `cpu_stall`: hold TAKE with `int_req` still high; `epc` unchanged.
    - Otherwise, at the edge: `epc <= pc_next`; clear `pending[int_id]`; `int_ack[int_id]`=1 for the following cycle; go to SERVICE.
    - A mask change during TAKE does not cancel the take.
  - SERVICE:
    - `int_code`=1; no new take.
    - On `eret`: go to IDLE.
    - `eret` in IDLE or TAKE is ignored.
- Reset values:
  - state IDLE;
  - `pending`, sync flops, `mask`, `epc`, `int_id`, `int_ack` = 0;
  - `int_req`, `int_code` = 0.
  - Reset in any state, including TAKE or SERVICE, abandons the service. A request lost this way must be re-raised.

## Timing
- `irq[i]` rises before edge E0:
  - `s1` at E0, `s2` at E1;
  - `pending` set at E2;
  - TAKE at E3;
  - `int_req` high E3–E4;
  - EPC captured, SERVICE entered and `int_ack` pulsed at E4.
- Minimum irq-to-`int_req` latency: 3 edges.
- `int_req`, `int_code`, `int_ack` and `int_id` are registered/state-decoded; no combinational path from `irq`.
- `eret` sampled at edge Ek in SERVICE: `int_code`=0 after Ek. If an eligible request remains, TAKE at Ek+1 and `int_req` after Ek+1.
- `int_vector` is valid whenever `int_req`=1 and stable through TAKE.
- `epc` holds its value from capture until the next capture or reset.

## Test plan
- Single request:
  - Stimulus: reset, write `mask`=0001, `pc_next`=0x40, pulse `irq[0]` before E0.
  - Required: `int_req`=1 only in E3–E4, `int_vector`=0x4; `epc`=0x40, `int_ack`=0001 and `int_code`=1 after E4.
- Priority and back-to-back:
  - Stimulus: `mask`=1111, `irq[1]` and `irq[3]` rise together.
  - Required: id 1 taken, vector 0x0C. After `eret`, `int_code`=0, then id 3 taken with vector 0x1C and no additional irq edge.
- Masking:
  - Stimulus: `mask`=0000, raise `irq[2]`.
  - Required: no `int_req` for 20 cycles. After writing `mask`=0100, TAKE one edge after the write, vector 0x14.
- Stall:
  - Stimulus: `cpu_stall`=1 for 3 cycles in TAKE, `pc_next` changing 0x80→0x84.
  - Required: `int_req` held for 4 cycles; `epc`=0x84 (value at the release edge); a single `int_ack` pulse.
- Spurious eret and edge collapse:
  - Stimulus: `eret` in IDLE; `irq[0]` toggled twice during SERVICE.
  - Required: the `eret` causes no state change; exactly one further take of id 0 follows the next `eret`.
- Reset mid-service:
  - Stimulus: assert `rst` in SERVICE with `epc`=0x40.
  - Required: after the edge, `int_code`=0, `epc`=0, `mask`=0, `pending`=0, state IDLE.
